pc_sequencer: RTL and testbench

//   Multi-cycle control FSM for the miniRV core. It sequences instruction fetch, decode,

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/WB control sequencer for the miniRV core.
// Issues memory requests, IR load, PC advance and RF write strobes; traps on illegal opcode or memory timeout.
module pc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  output logic             imem_req,
  input  logic             imem_rvalid,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_rvalid,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             halt,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_IMEM = 2'b10;
  localparam logic [1:0] CAUSE_DMEM = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_TRAP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [6:0]          op_q, op_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    instret_q, instret_d;

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    op_d      = op_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    cycle_d   = (state_q == S_TRAP) ? cycle_q : cycle_q + CNT_W'(1);
    case (state_q)
      S_FETCH: begin
        // rvalid on the last allowed wait cycle still wins over the timeout
        if (imem_rvalid) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_ALU, OP_ALUI, OP_LUI, OP_JALR: state_d = S_WB;
          OP_LOAD, OP_STORE:                state_d = S_MEM;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILL;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_rvalid) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      op_q      <= '0;
      cause_q   <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Requests and strobes are gated by reset_n so they fall the instant reset asserts.
  assign imem_req    = reset_n && (state_q == S_FETCH);
  assign ir_load     = imem_req && imem_rvalid;
  assign dmem_req    = reset_n && (state_q == S_MEM);
  assign dmem_we     = dmem_req && (op_q == OP_STORE);
  assign pc_en       = reset_n && (state_q == S_WB);
  assign pc_sel      = pc_en && (op_q == OP_JALR);
  assign rf_we       = pc_en && (op_q != OP_STORE);
  assign halt        = reset_n && (state_q == S_TRAP);
  assign trap_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle vector table plus hand-written timeout/trap/reset sequences.
module tb_pc_sequencer;

  localparam int CNT_W = 32;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ILL  = 7'b1111111;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [6:0]       opcode;
  logic             imem_req, imem_rvalid;
  logic             dmem_req, dmem_we, dmem_rvalid;
  logic             ir_load, pc_en, pc_sel, rf_we, halt;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  pc_sequencer #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode),
    .imem_req(imem_req), .imem_rvalid(imem_rvalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rvalid(dmem_rvalid),
    .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel), .rf_we(rf_we),
    .halt(halt), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // exp bits: {imem_req, ir_load, dmem_req, dmem_we, pc_en, pc_sel, rf_we, halt, trap_cause[1:0]}
  typedef struct packed {
    logic       rst_n;
    logic [6:0] op;
    logic       iv;
    logic       dv;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[23];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [9:0] outs();
    return {imem_req, ir_load, dmem_req, dmem_we, pc_en, pc_sel, rf_we, halt, trap_cause};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; imem_rvalid = 1'b0; dmem_rvalid = 1'b0; opcode = '0;
    @(negedge clk);
    reset_n = 1'b1;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //            rst   op    iv    dv    exp {ireq,irl,dreq,dwe,pce,psel,rfwe,halt,cause}
    tbl[0]  = '{1'b0, 7'h00, 1'b1, 1'b0, 10'b0000000000}; // in reset, all quiet
    tbl[1]  = '{1'b1, 7'h00, 1'b1, 1'b0, 10'b1100000000}; // FETCH hit
    tbl[2]  = '{1'b1, ADDI,  1'b0, 1'b0, 10'b0000000000}; // DECODE ADDI
    tbl[3]  = '{1'b1, JALR,  1'b0, 1'b0, 10'b0000101000}; // WB: opcode pin ignored
    tbl[4]  = '{1'b1, 7'h00, 1'b1, 1'b0, 10'b1100000000};
    tbl[5]  = '{1'b1, LW,    1'b0, 1'b0, 10'b0000000000};
    tbl[6]  = '{1'b1, SW,    1'b0, 1'b0, 10'b0010000000}; // MEM load, 3 waits
    tbl[7]  = '{1'b1, 7'h00, 1'b0, 1'b0, 10'b0010000000};
    tbl[8]  = '{1'b1, 7'h00, 1'b1, 1'b0, 10'b0010000000}; // stray imem_rvalid ignored
    tbl[9]  = '{1'b1, 7'h00, 1'b0, 1'b1, 10'b0010000000};
    tbl[10] = '{1'b1, SW,    1'b0, 1'b0, 10'b0000101000}; // WB load rf_we=1
    tbl[11] = '{1'b1, 7'h00, 1'b0, 1'b0, 10'b1000000000}; // FETCH wait
    tbl[12] = '{1'b1, 7'h00, 1'b1, 1'b0, 10'b1100000000};
    tbl[13] = '{1'b1, SW,    1'b0, 1'b0, 10'b0000000000};
    tbl[14] = '{1'b1, 7'h00, 1'b0, 1'b1, 10'b0011000000}; // MEM store
    tbl[15] = '{1'b1, 7'h00, 1'b0, 1'b0, 10'b0000100000}; // WB store rf_we=0
    tbl[16] = '{1'b1, 7'h00, 1'b1, 1'b1, 10'b1100000000}; // stray dmem_rvalid ignored
    tbl[17] = '{1'b1, JALR,  1'b0, 1'b0, 10'b0000000000};
    tbl[18] = '{1'b1, 7'h00, 1'b0, 1'b0, 10'b0000111000}; // WB JALR pc_sel=1
    tbl[19] = '{1'b1, 7'h00, 1'b1, 1'b0, 10'b1100000000};
    tbl[20] = '{1'b1, ILL,   1'b0, 1'b0, 10'b0000000000}; // DECODE illegal
    tbl[21] = '{1'b1, 7'h00, 1'b1, 1'b0, 10'b0000000101}; // TRAP cause 01
    tbl[22] = '{1'b1, ADDI,  1'b1, 1'b1, 10'b0000000101};

    reset_n = 1'b0; opcode = '0; imem_rvalid = 1'b0; dmem_rvalid = 1'b0;
    #2;
    chk("reset_outs", {54'd0, outs()}, 64'd0);
    chk("reset_cycle", cycle_cnt, 0);
    chk("reset_instret", instret_cnt, 0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      reset_n = tbl[i].rst_n; opcode = tbl[i].op;
      imem_rvalid = tbl[i].iv; dmem_rvalid = tbl[i].dv;
      #2;
      chk($sformatf("vec%0d", i), {54'd0, outs()}, {54'd0, tbl[i].exp});
    end
    chk("tbl_instret", instret_cnt, 4);
    chk("tbl_cycle_frozen", cycle_cnt, 20);

    // Trap is sticky: no fetch for 20 cycles even with rvalid pulsing
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_rvalid = 1'b1; dmem_rvalid = i[0];
      #2;
      chk($sformatf("trap_hold%0d", i), {54'd0, outs()}, {54'd0, 10'b0000000101});
    end
    chk("trap_cycle_frozen", cycle_cnt, 20);
    reset_n = 1'b0; #1; reset_n = 1'b1; #1;
    chk("trap_reset_pulse", {54'd0, outs()}, {54'd0, 10'b1100000000});
    chk("trap_reset_cnt", cycle_cnt, 0);

    // Five back-to-back ADDIs
    do_reset();
    for (int i = 0; i < 15; i++) begin
      imem_rvalid = (i % 3 == 0); opcode = (i % 3 == 1) ? ADDI : 7'h00;
      @(negedge clk);
    end
    imem_rvalid = 1'b0; #2;
    chk("addi5_instret", instret_cnt, 5);
    chk("addi5_cycle", cycle_cnt, 15);

    // imem timeout: still fetching after 15 waits, trapped after 16
    do_reset();
    repeat (15) @(negedge clk);
    #2;
    chk("imem_to_pre", {54'd0, outs()}, {54'd0, 10'b1000000000});
    @(negedge clk); #2;
    chk("imem_to_trap", {54'd0, outs()}, {54'd0, 10'b0000000110});
    chk("imem_to_cycle", cycle_cnt, 16);
    repeat (3) @(negedge clk);
    #2;
    chk("imem_to_frozen", cycle_cnt, 16);

    // rvalid on the timeout cycle wins
    do_reset();
    repeat (15) @(negedge clk);
    imem_rvalid = 1'b1; #2;
    chk("edge_rvalid_load", {54'd0, outs()}, {54'd0, 10'b1100000000});
    @(negedge clk);
    imem_rvalid = 1'b0; opcode = ADDI; #2;
    chk("edge_rvalid_decode", {54'd0, outs()}, 64'd0);
    @(negedge clk); #2;
    chk("edge_rvalid_wb", {54'd0, outs()}, {54'd0, 10'b0000101000});

    // dmem timeout on a load
    do_reset();
    imem_rvalid = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0; opcode = LW;
    @(negedge clk);
    opcode = 7'h00;
    repeat (15) @(negedge clk);
    #2;
    chk("dmem_to_pre", {54'd0, outs()}, {54'd0, 10'b0010000000});
    @(negedge clk); #2;
    chk("dmem_to_trap", {54'd0, outs()}, {54'd0, 10'b0000000111});

    // Async reset in MEM drops dmem_req immediately
    do_reset();
    imem_rvalid = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0; opcode = SW;
    @(negedge clk);
    opcode = 7'h00; #2;
    chk("mem_before_rst", {54'd0, outs()}, {54'd0, 10'b0011000000});
    #1 reset_n = 1'b0;
    #1;
    chk("mem_async_rst", {54'd0, outs()}, 64'd0);
    chk("mem_async_cnt", cycle_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
